mips_muldiv_unit: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers. It is the parametrised successor to the single-cycle MIPS ALU, adding MULT, MULTU, DIV, DIVU, MTHI and MTLO. It sits beside the ALU in the execute stage. The pipeline stalls on busy; MFHI and MFLO read the hi/lo outputs directly.

---
 rtl/mips_muldiv_unit.sv | 160 ++++++++++++++++
 tb/tb_mips_muldiv_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// One shift-add or restoring-division step per cycle; result lands on hi/lo only at completion.
module mips_muldiv_unit #(
  parameter int Data_Width = 32,
  parameter int Cnt_Width  = $clog2(Data_Width)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [Data_Width-1:0] data_in1,
  input  logic [Data_Width-1:0] data_in2,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero,
  output logic [Data_Width-1:0] hi,
  output logic [Data_Width-1:0] lo
);

  localparam int W = Data_Width;
  localparam logic [Cnt_Width-1:0] CNT_LAST = Cnt_Width'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [Cnt_Width-1:0] cnt;

  // Working register: multiply keeps {partial product, multiplier}; divide keeps {remainder, quotient}.
  logic [2*W:0]         acc;
  logic [W-1:0]         opnd;
  logic                 is_div;
  logic                 neg_q;
  logic                 neg_r;

  logic                 accept;
  logic                 op_mul;
  logic                 op_div;
  logic                 op_signed;
  logic                 op_dbz;
  logic                 s1;
  logic                 s2;
  logic [W-1:0]         mag1;
  logic [W-1:0]         mag2;

  logic [W:0]           mul_sum;
  logic [2*W:0]         mul_nxt;
  logic [2*W:0]         div_sh;
  logic [W:0]           div_diff;
  logic [2*W:0]         div_nxt;
  logic [2*W:0]         step;
  logic [2*W-1:0]       prod;
  logic [W-1:0]         res_hi;
  logic [W-1:0]         res_lo;

  function automatic logic [W-1:0] neg_w(input logic [W-1:0] x);
    return W'(0) - x;
  endfunction

  function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] x);
    return (2*W)'(0) - x;
  endfunction

  function automatic logic [W-1:0] magnitude(input logic [W-1:0] x, input logic sgn);
    return sgn ? neg_w(x) : x;
  endfunction

  always_comb begin
    accept    = start && (state != RUN);
    op_mul    = (op == 3'd0) || (op == 3'd1);
    op_div    = (op == 3'd2) || (op == 3'd3);
    op_signed = (op == 3'd0) || (op == 3'd2);
    op_dbz    = op_div && (data_in2 == '0);
    s1        = op_signed && data_in1[W-1];
    s2        = op_signed && data_in2[W-1];
    mag1      = magnitude(data_in1, s1);
    mag2      = magnitude(data_in2, s2);
  end

  always_comb begin
    mul_sum  = acc[0] ? (acc[2*W:W] + {1'b0, opnd}) : acc[2*W:W];
    mul_nxt  = {mul_sum, acc[W-1:0]} >> 1;
    div_sh   = {acc[2*W-1:0], 1'b0};
    div_diff = div_sh[2*W:W] - {1'b0, opnd};
    div_nxt  = div_diff[W] ? div_sh : {div_diff, div_sh[W-1:1], 1'b1};
    step     = is_div ? div_nxt : mul_nxt;
  end

  // Sign correction applied to the value the final step produces.
  always_comb begin
    prod = neg_q ? neg_2w(step[2*W-1:0]) : step[2*W-1:0];
    if (is_div) begin
      res_lo = neg_q ? neg_w(step[W-1:0]) : step[W-1:0];
      res_hi = neg_r ? neg_w(step[2*W-1:W]) : step[2*W-1:W];
    end else begin
      res_lo = prod[W-1:0];
      res_hi = prod[2*W-1:W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    if (accept) begin
      case (op)
        3'd0, 3'd1: state_nxt = RUN;
        3'd2, 3'd3: state_nxt = op_dbz ? DONE : RUN;
        default:    state_nxt = IDLE;
      endcase
    end else if (state == RUN) begin
      state_nxt = (cnt == '0) ? DONE : RUN;
    end
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      div_by_zero <= accept && op_dbz;
      if (accept) begin
        if (op == 3'd4) hi <= data_in1;
        if (op == 3'd5) lo <= data_in1;
        if ((op_mul || op_div) && !op_dbz) cnt <= CNT_LAST;
      end else if (state == RUN) begin
        if (cnt == '0) begin
          hi <= res_hi;
          lo <= res_lo;
        end else begin
          cnt <= cnt - Cnt_Width'(1);
        end
      end
    end
  end

  // Datapath registers carry no reset; they are always loaded at accept before use.
  always_ff @(posedge clk) begin
    if (accept && (op_mul || (op_div && !op_dbz))) begin
      acc    <= {{(W+1){1'b0}}, (op_div ? mag1 : mag2)};
      opnd   <= op_div ? mag2 : mag1;
      is_div <= op_div;
      neg_q  <= s1 ^ s2;
      neg_r  <= s1 && op_div;
    end else if (state == RUN) begin
      acc <= step;
    end
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit at the default width and at Data_Width=8.
module tb_mips_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, dbz;
  logic [31:0] hi, lo;

  logic        s_start = 1'b0;
  logic [2:0]  s_op = 3'd0;
  logic [7:0]  s_a = '0, s_b = '0;
  logic        s_busy, s_done, s_dbz;
  logic [7:0]  s_hi, s_lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .data_in1(a), .data_in2(b),
    .busy(busy), .done(done), .div_by_zero(dbz), .hi(hi), .lo(lo)
  );

  mips_muldiv_unit #(.Data_Width(8)) dut8 (
    .clk(clk), .rst(rst), .start(s_start), .op(s_op), .data_in1(s_a), .data_in2(s_b),
    .busy(s_busy), .done(s_done), .div_by_zero(s_dbz), .hi(s_hi), .lo(s_lo)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t tv[9];
  vec_t tv8[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int lat0, output int lat, output int bcnt);
    lat = lat0;
    bcnt = 0;
    while (!done && lat < 80) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic issue8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    s_start = 1'b1; s_op = o; s_a = x; s_b = y;
    @(negedge clk);
    s_start = 1'b0;
  endtask

  task automatic wait_done8(output int lat, output int bcnt);
    lat = 1;
    bcnt = 0;
    while (!s_done && lat < 40) begin
      if (s_busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, bc, seen;

    tv[0] = '{3'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    tv[1] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    tv[2] = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    tv[3] = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tv[4] = '{3'd3, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003};
    tv[5] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    tv[6] = '{3'd1, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
    tv[7] = '{3'd2, 32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2};
    tv[8] = '{3'd3, 32'hFFFF_FFFF, 32'h0000_000A, 32'h0000_0005, 32'h1999_9999};

    tv8[0] = '{3'd0, 32'hFD, 32'h05, 32'hFF, 32'hF1};
    tv8[1] = '{3'd2, 32'hF9, 32'h02, 32'hFF, 32'hFD};
    tv8[2] = '{3'd3, 32'h07, 32'h02, 32'h01, 32'h03};
    tv8[3] = '{3'd1, 32'hFF, 32'hFF, 32'hFE, 32'h01};
    tv8[4] = '{3'd2, 32'h80, 32'hFF, 32'h00, 32'h80};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_dbz", {63'd0, dbz}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset8_hilo", {48'd0, s_hi, s_lo}, 64'd0);

    for (int i = 0; i < 9; i++) begin
      issue(tv[i].op, tv[i].a, tv[i].b);
      wait_done(1, lat, bc);
      chk($sformatf("v%0d_hi", i), {32'd0, hi}, {32'd0, tv[i].hi});
      chk($sformatf("v%0d_lo", i), {32'd0, lo}, {32'd0, tv[i].lo});
      chk($sformatf("v%0d_dbz", i), {63'd0, dbz}, 64'd0);
      chk($sformatf("v%0d_latency", i), lat, 64'd33);
      chk($sformatf("v%0d_busy_cycles", i), bc, 64'd32);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), {63'd0, done}, 64'd0);
    end

    issue(3'd4, 32'h0000_1234, 32'hAAAA_AAAA);
    chk("mthi_busy", {62'd0, busy, done}, 64'd0);
    chk("mthi_hi", {32'd0, hi}, 64'h1234);
    issue(3'd5, 32'h0000_5678, 32'h5555_5555);
    chk("mtlo_lo", {32'd0, lo}, 64'h5678);
    chk("mtlo_hi_kept", {32'd0, hi}, 64'h1234);

    issue(3'd3, 32'h0000_0063, 32'h0000_0000);
    chk("dbz_done", {63'd0, done}, 64'd1);
    chk("dbz_flag", {63'd0, dbz}, 64'd1);
    chk("dbz_busy", {63'd0, busy}, 64'd0);
    chk("dbz_hilo", {hi, lo}, 64'h0000_1234_0000_5678);
    @(negedge clk);
    chk("dbz_flag_clear", {62'd0, done, dbz}, 64'd0);

    issue(3'd6, 32'hDEAD_BEEF, 32'h0000_0003);
    chk("rsv_state", {62'd0, busy, done}, 64'd0);
    @(negedge clk);
    chk("rsv_state2", {62'd0, busy, done}, 64'd0);
    chk("rsv_hilo", {hi, lo}, 64'h0000_1234_0000_5678);

    issue(3'd0, 32'd3, 32'd4);
    repeat (9) @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd7; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done(11, lat, bc);
    chk("hazard_start_hilo", {hi, lo}, 64'd12);
    chk("hazard_start_latency", lat, 64'd33);
    @(negedge clk);

    issue(3'd0, 32'hFFFF_FFFD, 32'd5);
    repeat (14) @(negedge clk);
    chk("pre_reset_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort_no_done", seen, 64'd0);

    issue(3'd3, 32'd7, 32'd2);
    wait_done(1, lat, bc);
    chk("b2b_first_hilo", {hi, lo}, 64'h0000_0001_0000_0003);
    start = 1'b1; op = 3'd0; a = 32'hFFFF_FFFD; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", {62'd0, busy, done}, 64'd2);
    wait_done(1, lat, bc);
    chk("b2b_second_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    chk("b2b_latency", lat, 64'd33);
    chk("b2b_busy_cycles", bc, 64'd32);

    for (int i = 0; i < 5; i++) begin
      issue8(tv8[i].op, tv8[i].a[7:0], tv8[i].b[7:0]);
      wait_done8(lat, bc);
      chk($sformatf("w8_v%0d_hilo", i), {48'd0, s_hi, s_lo}, {48'd0, tv8[i].hi[7:0], tv8[i].lo[7:0]});
      chk($sformatf("w8_v%0d_latency", i), lat, 64'd9);
      chk($sformatf("w8_v%0d_busy_cycles", i), bc, 64'd8);
      chk($sformatf("w8_v%0d_dbz", i), {63'd0, s_dbz}, 64'd0);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
